// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic-array output drain.
package sa_pkg;

  localparam int SA_R  = 4;
  localparam int SA_C  = 4;
  localparam int SA_WY = 16;
  localparam int SA_WO = 8;

  // Row counter width: $clog2(r), never narrower than one bit (r=1 still needs a counter bit).
  function automatic int row_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  localparam int ROW_W = row_w(SA_R);

  typedef logic signed [SA_WY-1:0] acc_t;
  typedef logic signed [SA_WO-1:0] out_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/sa_out_drain_sat_clip.sv
// Signed saturate (narrowing) or sign-extend (widening) of one element.
module sat_clip #(
  parameter int WI = 16,
  parameter int WO = 8
) (
  input  logic [WI-1:0] din_i,
  output logic [WO-1:0] dout_o
);

  generate
    if (WO == WI) begin : g_pass
      assign dout_o = din_i;
    end else if (WO > WI) begin : g_ext
      assign dout_o = {{(WO-WI){din_i[WI-1]}}, din_i};
    end else begin : g_clip
      // Value fits when every bit from the sign down to the output sign bit agrees.
      logic [WI-WO:0] top_bits;
      logic           ovf;
      assign top_bits = din_i[WI-1:WO-1];
      assign ovf      = !((&top_bits) || !(|top_bits));
      assign dout_o   = !ovf        ? din_i[WO-1:0] :
                        din_i[WI-1] ? {1'b1, {(WO-1){1'b0}}} :
                                      {1'b0, {(WO-1){1'b1}}};
    end
  endgenerate

endmodule

// File: rtl/sa_out_drain.sv
// Captures a full R x C accumulator tile and streams it out one saturated row
// per AXIS beat. The next tile can be captured on the last beat of the current one.
module sa_out_drain
  import sa_pkg::*;
#(
  parameter int R  = 4,
  parameter int C  = 4,
  parameter int WY = 16,
  parameter int WO = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [R*C*WY-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [C*WO-1:0]   m_data,
  output logic              m_last
);

  localparam int RW = row_w(R);
  localparam int RB = C*WY;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [R*C*WY-1:0] tile_q, tile_d;
  logic              last_row;
  logic [RB-1:0]     row_data;
  logic [C*WO-1:0]   sat_row;

  assign last_row = (row_q == RW'(R-1));
  assign m_valid  = (state_q == ST_FULL);
  assign m_last   = m_valid && last_row;
  assign m_data   = m_valid ? sat_row : '0;

  // Upstream may hand over a tile when empty or when the final beat is leaving.
  always_comb begin
    s_ready = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && last_row && m_ready);
  end

  // Select the current row out of the shadow buffer.
  always_comb begin
    row_data = '0;
    for (int r = 0; r < R; r++) begin
      if (row_q == RW'(r)) row_data = tile_q[r*RB +: RB];
    end
  end

  // One saturator per column on the selected row.
  generate
    for (genvar c = 0; c < C; c++) begin : g_col
      sat_clip #(.WI(WY), .WO(WO)) u_sat (
        .din_i  (row_data[c*WY +: WY]),
        .dout_o (sat_row[c*WO +: WO])
      );
    end
  endgenerate

  // Next-state: capture, row advance, and return to empty after the last beat.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tile_d  = tile_q;
    case (state_q)
      ST_EMPTY: begin
        if (s_valid) begin
          tile_d  = s_data;
          row_d   = '0;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (m_ready) begin
          if (!last_row) begin
            row_d = row_q + 1'b1;
          end else if (s_valid) begin
            tile_d = s_data;
            row_d  = '0;
          end else begin
            row_d   = '0;
            state_d = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        row_d   = '0;
      end
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Tile buffer needs no reset: it is only read while FULL.
  always_ff @(posedge clk) begin
    tile_q <= tile_d;
  end

endmodule

// File: tb/tb_sa_out_drain.sv
// Bench for sa_out_drain: directed table, hand sequences, random traffic against
// a queue-of-beats reference model, and two alternate parameterisations.
module tb_sa_out_drain;

  logic         clk, rstn;
  logic         s_valid, s_ready, m_valid, m_ready, m_last;
  logic [255:0] s_data;
  logic [31:0]  m_data;

  // R=1, C=2, WO=20 (widening)
  logic        a_sv, a_sr, a_mv, a_mr, a_ml;
  logic [31:0] a_sd;
  logic [39:0] a_md;
  // R=3, C=2, WO=8
  logic        b_sv, b_sr, b_mv, b_mr, b_ml;
  logic [95:0] b_sd;
  logic [15:0] b_md;

  int checks = 0, failures = 0;

  sa_out_drain #(.R(4), .C(4), .WY(16), .WO(8)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last));

  sa_out_drain #(.R(1), .C(2), .WY(16), .WO(20)) dut_a (
    .clk(clk), .rstn(rstn), .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
    .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md), .m_last(a_ml));

  sa_out_drain #(.R(3), .C(2), .WY(16), .WO(8)) dut_b (
    .clk(clk), .rstn(rstn), .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
    .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md), .m_last(b_ml));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: clamp to the signed WO range, return low WO bits.
  function automatic int satv(input int v, input int wo);
    int mx, mn;
    mx = (1 << (wo-1)) - 1;
    mn = -(1 << (wo-1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic logic [31:0] beat_of(input logic [255:0] t, input int r);
    logic [31:0] res;
    int v;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      v = int'($signed(t[(r*4+c)*16 +: 16]));
      res[c*8 +: 8] = 8'(satv(v, 8));
    end
    return res;
  endfunction

  function automatic logic [255:0] rnd_tile();
    logic [255:0] t;
    for (int i = 0; i < 16; i++)
      t[i*16 +: 16] = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 255) - 128);
    return t;
  endfunction

  // Model: queue of beats still owed downstream.
  logic [31:0] exp_q[$];
  bit          acc;
  int          beats_seen = 0, lasts_seen = 0;

  typedef struct {
    bit           sv;
    bit           mr;
    logic [255:0] sd;
    bit           e_sr;
    bit           e_mv;
    bit           e_ml;
    logic [31:0]  e_d;
  } vec_t;
  vec_t tbl[13];
  int   tbl_i = -1;

  // One clock: compare at negedge, advance the model at posedge, return just after.
  task automatic tick(input string tag);
    bit sr_exp;
    @(negedge clk);
    sr_exp = (exp_q.size() == 0) || (exp_q.size() == 1 && m_ready);
    chk({tag, " s_ready"}, 64'(s_ready), 64'(sr_exp));
    chk({tag, " m_valid"}, 64'(m_valid), 64'(exp_q.size() > 0));
    chk({tag, " m_last"},  64'(m_last),  64'(exp_q.size() == 1));
    chk({tag, " m_data"},  64'(m_data),  64'((exp_q.size() > 0) ? exp_q[0] : 32'h0));
    if (tbl_i >= 0) begin
      chk($sformatf("tbl%0d s_ready", tbl_i), 64'(s_ready), 64'(tbl[tbl_i].e_sr));
      chk($sformatf("tbl%0d m_valid", tbl_i), 64'(m_valid), 64'(tbl[tbl_i].e_mv));
      chk($sformatf("tbl%0d m_last", tbl_i),  64'(m_last),  64'(tbl[tbl_i].e_ml));
      chk($sformatf("tbl%0d m_data", tbl_i),  64'(m_data),  64'(tbl[tbl_i].e_d));
    end
    if (m_valid && m_ready) begin
      beats_seen++;
      if (m_last) lasts_seen++;
    end
    @(posedge clk);
    acc = 1'b0;
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && m_ready) void'(exp_q.pop_front());
      if (s_valid && sr_exp) begin
        acc = 1'b1;
        for (int r = 0; r < 4; r++) exp_q.push_back(beat_of(s_data, r));
      end
    end
    #1;
  endtask

  initial begin
    logic [255:0] t1, ts, ta, tb;
    int b0, l0;

    rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    a_sv = 1'b0; a_mr = 1'b0; a_sd = '0;
    b_sv = 1'b0; b_mr = 1'b0; b_sd = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst s_ready", 64'(s_ready), 64'd1);
    chk("rst m_valid", 64'(m_valid), 64'd0);
    chk("rst m_last",  64'(m_last),  64'd0);
    chk("rst m_data",  64'(m_data),  64'd0);
    @(posedge clk); #1;

    // Directed table: ramp tile, then saturation tile with a stall on beat 0
    for (int i = 0; i < 16; i++) t1[i*16 +: 16] = 16'(i);
    ts = '0;
    ts[63:0]   = {16'hFF80, 16'h007F, 16'hFED4, 16'h00C8};
    ts[127:64] = {4{16'hFFFF}};
    tbl[0]  = '{1, 1, t1, 1, 0, 0, 32'h0};
    tbl[1]  = '{0, 1, t1, 0, 1, 0, 32'h03020100};
    tbl[2]  = '{0, 1, t1, 0, 1, 0, 32'h07060504};
    tbl[3]  = '{0, 1, t1, 0, 1, 0, 32'h0B0A0908};
    tbl[4]  = '{0, 1, t1, 1, 1, 1, 32'h0F0E0D0C};
    tbl[5]  = '{0, 1, t1, 1, 0, 0, 32'h0};
    tbl[6]  = '{1, 0, ts, 1, 0, 0, 32'h0};
    tbl[7]  = '{0, 0, ts, 0, 1, 0, 32'h807F807F};
    tbl[8]  = '{0, 1, ts, 0, 1, 0, 32'h807F807F};
    tbl[9]  = '{0, 1, ts, 0, 1, 0, 32'hFFFFFFFF};
    tbl[10] = '{0, 0, ts, 0, 1, 0, 32'h0};
    tbl[11] = '{0, 1, ts, 0, 1, 0, 32'h0};
    tbl[12] = '{0, 1, ts, 1, 1, 1, 32'h0};
    for (int i = 0; i < 13; i++) begin
      s_valid = tbl[i].sv; m_ready = tbl[i].mr; s_data = tbl[i].sd;
      tbl_i = i;
      tick("tbl");
    end
    tbl_i = -1;
    s_valid = 1'b0;
    tick("idle");

    // Back-to-back tiles: B is offered as soon as A is taken
    ta = rnd_tile(); tb = rnd_tile();
    m_ready = 1'b1; s_valid = 1'b1; s_data = ta;
    tick("b2b");
    s_data = tb;
    b0 = beats_seen; l0 = lasts_seen;
    for (int k = 0; k < 9; k++) begin
      tick("b2b");
      if (acc) s_valid = 1'b0;
    end
    chk("b2b beats", 64'(beats_seen - b0), 64'd8);
    chk("b2b lasts", 64'(lasts_seen - l0), 64'd2);

    // s_valid held mid-tile must not capture; reset after two beats drops the rest
    s_data = rnd_tile(); s_valid = 1'b1; m_ready = 1'b1;
    tick("rst_mid");
    s_data = rnd_tile();
    tick("rst_mid");
    tick("rst_mid");
    rstn = 1'b0;
    tick("rst_mid");
    rstn = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid m_valid", 64'(m_valid), 64'd0);
    chk("rst_mid s_ready", 64'(s_ready), 64'd1);
    chk("rst_mid m_last",  64'(m_last),  64'd0);
    @(posedge clk); #1;
    s_data = rnd_tile(); s_valid = 1'b1;
    tick("post_rst");
    s_valid = 1'b0;
    repeat (5) tick("post_rst");

    // Random traffic with back-pressure
    for (int k = 0; k < 600; k++) begin
      if (!s_valid && ($urandom % 3 == 0)) begin
        s_valid = 1'b1;
        s_data  = rnd_tile();
      end
      m_ready = ($urandom % 4) != 0;
      tick("rnd");
      if (acc) s_valid = 1'b0;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (6) tick("drain");

    // R=1, WO=20: sign extension, s_ready follows m_ready while FULL
    a_sd = {16'd7, 16'hFFFB}; a_sv = 1'b1; a_mr = 1'b0;
    @(negedge clk);
    chk("r1 idle s_ready", 64'(a_sr), 64'd1);
    chk("r1 idle m_valid", 64'(a_mv), 64'd0);
    @(posedge clk); #1 a_sv = 1'b0;
    @(negedge clk);
    chk("r1 m_valid",       64'(a_mv), 64'd1);
    chk("r1 m_last",        64'(a_ml), 64'd1);
    chk("r1 m_data",        64'(a_md), 64'h00007FFFFB);
    chk("r1 stall s_ready", 64'(a_sr), 64'd0);
    a_mr = 1'b1;
    #1 chk("r1 go s_ready", 64'(a_sr), 64'd1);
    @(posedge clk); #1 a_mr = 1'b0;
    @(negedge clk);
    chk("r1 empty m_valid", 64'(a_mv), 64'd0);

    // R=3, C=2: three beats, last on the third
    b_sd = {16'd9, 16'hFC18, 16'd5, 16'd300, 16'd1, 16'hFFFD};
    b_sv = 1'b1; b_mr = 1'b1;
    @(posedge clk); #1 b_sv = 1'b0;
    @(negedge clk);
    chk("r3 b0 data", 64'(b_md), 64'h01FD);
    chk("r3 b0 last", 64'(b_ml), 64'd0);
    chk("r3 b0 s_ready", 64'(b_sr), 64'd0);
    @(negedge clk);
    chk("r3 b1 data", 64'(b_md), 64'h057F);
    chk("r3 b1 last", 64'(b_ml), 64'd0);
    @(negedge clk);
    chk("r3 b2 data", 64'(b_md), 64'h0980);
    chk("r3 b2 last", 64'(b_ml), 64'd1);
    chk("r3 b2 valid", 64'(b_mv), 64'd1);
    @(negedge clk);
    chk("r3 done valid", 64'(b_mv), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
